// File: rtl/window_ctrl.sv
// rtl/window_ctrl.sv - window buffer fill / feature-issue / release sequencer
// Optional watchdog enabled by defining WINDOW_CTRL_TIMEOUT_EN.
module window_ctrl #(
    parameter int W_DATA          = 18,
    parameter int WINDOW_WIDTH    = 24,
    parameter int WINDOW_HEIGHT   = 24,
    parameter int MAX_OUTSTANDING = 4,
    parameter int W_WIN_CNT       = 16,
    parameter int TIMEOUT_CYCLES  = 1024,
    localparam int DEPTH          = WINDOW_WIDTH * WINDOW_HEIGHT,
    localparam int W_ADDR         = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic [W_DATA-1:0]    pix_data,
    output logic                 buf_din_valid,
    input  logic                 buf_din_ready,
    output logic [W_DATA-1:0]    buf_din_data,
    output logic [1:0]           buf_din_eot,
    input  logic                 feat_valid,
    output logic                 feat_ready,
    input  logic [W_ADDR-1:0]    feat_addr0,
    input  logic [W_ADDR-1:0]    feat_addr1,
    input  logic [W_ADDR-1:0]    feat_addr2,
    input  logic                 feat_last,
    output logic                 buf_addr_valid,
    input  logic                 buf_addr_ready,
    output logic [W_ADDR-1:0]    buf_addr0,
    output logic [W_ADDR-1:0]    buf_addr1,
    output logic [W_ADDR-1:0]    buf_addr2,
    input  logic                 buf_dout_valid,
    input  logic                 buf_dout_ready,
    input  logic                 stage_reject,
    output logic                 buf_release,
    output logic                 feat_restart,
    output logic                 busy,
    output logic [W_WIN_CNT-1:0] win_count,
    output logic                 err_timeout
);

    localparam int W_OUT = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_EVAL,
        S_DRAIN,
        S_RELEASE
    } state_t;

    state_t            state;
    logic [W_ADDR-1:0] fill_cnt;
    logic [W_OUT-1:0]  outstanding;
    logic [W_OUT-1:0]  out_next;

    logic in_fill;
    logic in_eval;
    logic fill_last;
    logic room;
    logic wr;
    logic issue;
    logic resp;
    logic wd_fire;

    assign in_fill   = (state == S_FILL);
    assign in_eval   = (state == S_EVAL);
    assign fill_last = (fill_cnt == W_ADDR'(DEPTH - 1));
    assign room      = (outstanding < W_OUT'(MAX_OUTSTANDING));

    assign pix_ready      = in_fill & buf_din_ready;
    assign buf_din_valid  = in_fill & pix_valid;
    assign buf_din_data   = in_fill ? pix_data : '0;
    assign buf_din_eot    = {2{in_fill & fill_last}};

    assign buf_addr_valid = in_eval & feat_valid & room;
    assign feat_ready     = in_eval & buf_addr_ready & room;
    assign buf_addr0      = in_eval ? feat_addr0 : '0;
    assign buf_addr1      = in_eval ? feat_addr1 : '0;
    assign buf_addr2      = in_eval ? feat_addr2 : '0;

    assign wr    = buf_din_valid & buf_din_ready;
    assign issue = buf_addr_valid & buf_addr_ready;
    assign resp  = buf_dout_valid & buf_dout_ready;

    // A response with nothing in flight is a protocol error; hold at zero.
    always_comb begin
        out_next = outstanding;
        if (issue && !resp) begin
            out_next = outstanding + 1'b1;
        end else if (!issue && resp && (outstanding != '0)) begin
            out_next = outstanding - 1'b1;
        end
    end

`ifdef WINDOW_CTRL_TIMEOUT_EN
    localparam int W_WD = $clog2(TIMEOUT_CYCLES + 1);

    logic [W_WD-1:0] wd_cnt;
    logic            stall;

    assign stall   = ((state == S_EVAL) || (state == S_DRAIN)) && (outstanding != '0) && !resp;
    assign wd_fire = stall && (wd_cnt == W_WD'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (stall && !wd_fire) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
            if (wd_fire) begin
                err_timeout <= 1'b1;
            end
        end
    end
`else
    assign wd_fire     = 1'b0;
    assign err_timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            fill_cnt     <= '0;
            outstanding  <= '0;
            win_count    <= '0;
            buf_release  <= 1'b0;
            feat_restart <= 1'b0;
            busy         <= 1'b0;
        end else begin
            buf_release  <= 1'b0;
            feat_restart <= 1'b0;
            outstanding  <= out_next;
            case (state)
                S_IDLE: begin
                    if (en) begin
                        state <= S_FILL;
                        busy  <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (wr) begin
                        if (fill_last) begin
                            fill_cnt <= '0;
                            state    <= S_EVAL;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                end
                S_EVAL: begin
                    // A coincident reject still leaves that triplet counted in out_next.
                    if (stage_reject || (issue && feat_last)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_next == '0) begin
                        state        <= S_RELEASE;
                        buf_release  <= 1'b1;
                        feat_restart <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    win_count <= win_count + 1'b1;
                    if (en) begin
                        state <= S_FILL;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // Watchdog abandons the in-flight reads and forces the window out.
            if (wd_fire) begin
                state        <= S_RELEASE;
                outstanding  <= '0;
                buf_release  <= 1'b1;
                feat_restart <= 1'b1;
            end
        end
    end

endmodule
